// File: rtl/rx_link_ctrl_pkg.sv
// Shared definitions for the receive-side link controller: FSM state encodings,
// bit positions and field widths, and the even-parity helper.
package rx_link_ctrl_pkg;

  localparam int PAR_BIT   = 9;
  localparam int PAYLOAD_W = 9;
  localparam int ERRCNT_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  // A word is good when the total count of ones, parity bit included, is even.
  function automatic logic parity_even(input logic [PAR_BIT:0] word);
    return ~^word;
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Show-ahead FIFO for accepted payloads. Pointers wrap modulo DEPTH (power of two);
// push on full and pop on empty are ignored. The head reads as zero while empty.
module rx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // NOTE: storage has no reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rx_link_ctrl.sv
// Receive-side link controller: captures parity-protected words under a valid/ack/nack
// handshake, retries on parity errors and queues good payloads. Optional RX_ERR_COUNT_EN.
module rx_link_ctrl
  import rx_link_ctrl_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  input  logic [PAR_BIT:0]     tx_data,
  output logic                 tx_ack,
  output logic                 tx_nack,
  output logic                 drop,
  output logic [PAYLOAD_W-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 fifo_full
`ifdef RX_ERR_COUNT_EN
  ,
  output logic [ERRCNT_W-1:0]  err_count
`endif
);

  localparam int RW = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  state_t             state, state_nx;
  logic [PAR_BIT:0]   word_q, word_nx;
  logic [RW-1:0]      retry_cnt, retry_nx;
  logic               ack_nx, nack_nx, drop_nx;
  logic               push;
  logic               parity_ok;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;

  assign parity_ok = parity_even(word_q);
  assign fifo_full = (fifo_count == CW'(DEPTH));
  assign rx_valid  = ~fifo_empty;

  // NOTE: every variable gets a default first, so no path through the case infers a latch.
  always_comb begin
    state_nx = state;
    word_nx  = word_q;
    retry_nx = retry_cnt;
    ack_nx   = 1'b0;
    nack_nx  = 1'b0;
    drop_nx  = 1'b0;
    push     = 1'b0;
    unique case (state)
      S_IDLE: begin
        // A full FIFO stalls the transmitter rather than risking a push with no room.
        if (tx_valid && !fifo_full) begin
          word_nx  = tx_data;
          state_nx = S_CHECK;
        end
      end
      S_CHECK: begin
        state_nx = S_RESP;
        if (parity_ok) begin
          push     = 1'b1;
          ack_nx   = 1'b1;
          retry_nx = '0;
        end else if (retry_cnt < RW'(MAX_RETRY)) begin
          nack_nx  = 1'b1;
          retry_nx = retry_cnt + RW'(1);
        end else begin
          ack_nx   = 1'b1;
          drop_nx  = 1'b1;
          retry_nx = '0;
        end
      end
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      word_q    <= '0;
      retry_cnt <= '0;
      tx_ack    <= 1'b0;
      tx_nack   <= 1'b0;
      drop      <= 1'b0;
    end else begin
      state     <= state_nx;
      word_q    <= word_nx;
      retry_cnt <= retry_nx;
      tx_ack    <= ack_nx;
      tx_nack   <= nack_nx;
      drop      <= drop_nx;
    end
  end

`ifdef RX_ERR_COUNT_EN
  logic err_inc;
  assign err_inc = (state == S_CHECK) && !parity_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 err_count <= '0;
    else if (err_inc && (err_count != '1))     err_count <= err_count + ERRCNT_W'(1);
  end
`endif

  rx_fifo #(
    .WIDTH (PAYLOAD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (word_q[PAYLOAD_W-1:0]),
    .pop   (rx_ready),
    .rdata (rx_data),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_rx_link_ctrl.sv
// Directed testbench for rx_link_ctrl (DEPTH=4, MAX_RETRY=3); err_count checks
// are compiled in only when RX_ERR_COUNT_EN is defined.
module tb_rx_link_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_valid;
  logic [9:0] tx_data;
  logic       tx_ack, tx_nack, drop;
  logic [8:0] rx_data;
  logic       rx_valid, rx_ready, fifo_full;
`ifdef RX_ERR_COUNT_EN
  logic [7:0] err_count;
  int         exp_err = 0;
`endif

  int total = 0;
  int bad   = 0;

  rx_link_ctrl #(.DEPTH(4), .MAX_RETRY(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ack    (tx_ack),
    .tx_nack   (tx_nack),
    .drop      (drop),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .fifo_full (fifo_full)
`ifdef RX_ERR_COUNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  // Starts on a falling edge; holds the word until a response or the budget runs out.
  // lat is the number of falling edges after the first one on which the response showed.
  task automatic handshake(input logic [9:0] d, input int budget,
                           output logic a, output logic n, output logic dr, output int lat);
    tx_valid = 1'b1;
    tx_data  = d;
    a = 1'b0; n = 1'b0; dr = 1'b0; lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_ack || tx_nack) begin
        a = tx_ack; n = tx_nack; dr = drop; lat = i;
        break;
      end
    end
    tx_valid = 1'b0;
  endtask

  task automatic pop_expect(input logic [8:0] exp, input string name);
    total++;
    if (rx_valid !== 1'b1 || rx_data !== exp) begin
      bad++;
      $display("FAIL %s: rx_valid=%b rx_data=%h, expected 1/%h", name, rx_valid, rx_data, exp);
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({tx_ack, tx_nack, drop, rx_valid, fifo_full, rx_data} !== 14'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %b, expected all zero",
               {tx_ack, tx_nack, drop, rx_valid, fifo_full, rx_data});
    end
`ifdef RX_ERR_COUNT_EN
    total++;
    if (err_count !== 8'd0) begin bad++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
`endif
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_good_word();
    logic a, n, dr; int lat;
    handshake(10'h0A5, 8, a, n, dr, lat);
    total++;
    if ({a, n, dr} !== 3'b100 || lat !== 1) begin
      bad++;
      $display("FAIL good_ack: ack/nack/drop=%b lat=%0d, expected 100 lat=1", {a, n, dr}, lat);
    end
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 9'h0A5) begin
      bad++;
      $display("FAIL good_data: rx_valid=%b rx_data=%h, expected 1/0a5", rx_valid, rx_data);
    end
    @(negedge clk);
    total++;
    if (tx_ack !== 1'b0) begin bad++; $display("FAIL ack_pulse_width: tx_ack=%b expected 0", tx_ack); end
    pop_expect(9'h0A5, "good_pop");
    total++;
    if (rx_valid !== 1'b0) begin bad++; $display("FAIL good_empty: rx_valid=%b expected 0", rx_valid); end
  endtask

  task automatic test_retry_drop();
    logic a, n, dr; int lat;
    for (int k = 0; k < 3; k++) begin
      handshake(10'h0A4, 8, a, n, dr, lat);
      total++;
      if ({a, n, dr} !== 3'b010) begin
        bad++;
        $display("FAIL retry_nack%0d: ack/nack/drop=%b, expected 010", k, {a, n, dr});
      end
    end
    handshake(10'h0A4, 8, a, n, dr, lat);
    total++;
    if ({a, n, dr} !== 3'b101) begin
      bad++;
      $display("FAIL retry_drop: ack/nack/drop=%b, expected 101", {a, n, dr});
    end
    @(negedge clk);
    total++;
    if (rx_valid !== 1'b0 || drop !== 1'b0) begin
      bad++;
      $display("FAIL drop_no_push: rx_valid=%b drop=%b, expected 0/0", rx_valid, drop);
    end
`ifdef RX_ERR_COUNT_EN
    exp_err += 4;
    total++;
    if (err_count !== 8'(exp_err)) begin bad++; $display("FAIL err_count_drop: got %0d expected %0d", err_count, exp_err); end
`endif
  endtask

  task automatic test_retry_recover();
    logic a, n, dr; int lat;
    handshake(10'h0A4, 8, a, n, dr, lat);
    total++;
    if ({a, n, dr} !== 3'b010) begin bad++; $display("FAIL recover_nack: got %b expected 010", {a, n, dr}); end
    handshake(10'h2A4, 8, a, n, dr, lat);
    total++;
    if ({a, n, dr} !== 3'b100) begin bad++; $display("FAIL recover_ack: got %b expected 100", {a, n, dr}); end
    total++;
    if (dut.retry_cnt !== 4'd0) begin bad++; $display("FAIL recover_retry_cnt: got %0d expected 0", dut.retry_cnt); end
    @(negedge clk);
    pop_expect(9'h0A4, "recover_data");
`ifdef RX_ERR_COUNT_EN
    exp_err += 1;
    total++;
    if (err_count !== 8'(exp_err)) begin bad++; $display("FAIL err_count_recover: got %0d expected %0d", err_count, exp_err); end
`endif
  endtask

  task automatic test_full_stall();
    logic a, n, dr; int lat;
    logic [9:0] words [5] = '{10'h003, 10'h005, 10'h006, 10'h009, 10'h00A};
    for (int k = 0; k < 4; k++) begin
      handshake(words[k], 8, a, n, dr, lat);
      total++;
      if ({a, n, dr} !== 3'b100) begin bad++; $display("FAIL fill_ack%0d: got %b expected 100", k, {a, n, dr}); end
      @(negedge clk);
    end
    total++;
    if (fifo_full !== 1'b1) begin bad++; $display("FAIL fifo_full: got %b expected 1", fifo_full); end
    handshake(words[4], 6, a, n, dr, lat);
    total++;
    if ({a, n, dr} !== 3'b000) begin bad++; $display("FAIL full_stall: got %b expected no response", {a, n, dr}); end
    pop_expect(9'h003, "stall_pop0");
    handshake(words[4], 8, a, n, dr, lat);
    total++;
    if ({a, n, dr} !== 3'b100) begin bad++; $display("FAIL after_pop_ack: got %b expected 100", {a, n, dr}); end
    @(negedge clk);
    for (int k = 1; k < 5; k++) pop_expect(words[k][8:0], "stall_order");
    total++;
    if (rx_valid !== 1'b0) begin bad++; $display("FAIL stall_drained: rx_valid=%b expected 0", rx_valid); end
  endtask

  task automatic test_push_pop_same_cycle();
    logic a, n, dr; int lat;
    logic [9:0] words [3] = '{10'h011, 10'h012, 10'h014};
    for (int k = 0; k < 3; k++) begin
      handshake(words[k], 8, a, n, dr, lat);
      @(negedge clk);
    end
    tx_valid = 1'b1;
    tx_data  = 10'h018;
    @(negedge clk);                // word captured, CHECK cycle: the push edge is next
    total++;
    if (rx_data !== 9'h011) begin bad++; $display("FAIL pp_head_before: got %h expected 011", rx_data); end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    total++;
    if (tx_ack !== 1'b1 || dut.fifo_count !== 3'd3) begin
      bad++;
      $display("FAIL pp_count: tx_ack=%b count=%0d, expected 1/3", tx_ack, dut.fifo_count);
    end
    @(negedge clk);
    pop_expect(9'h012, "pp_order");
    pop_expect(9'h014, "pp_order");
    pop_expect(9'h018, "pp_order");
    total++;
    if (rx_valid !== 1'b0) begin bad++; $display("FAIL pp_drained: rx_valid=%b expected 0", rx_valid); end
  endtask

  task automatic test_reset_mid_op();
    logic a, n, dr; int lat;
    handshake(10'h021, 8, a, n, dr, lat);
    @(negedge clk);
    handshake(10'h022, 8, a, n, dr, lat);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 10'h024;
    @(negedge clk);                // in CHECK with two entries queued
    reset = 1'b1;
    #1;
    total++;
    if ({tx_ack, tx_nack, drop, rx_valid, fifo_full, rx_data} !== 14'd0) begin
      bad++;
      $display("FAIL midreset_outputs: got %b, expected all zero",
               {tx_ack, tx_nack, drop, rx_valid, fifo_full, rx_data});
    end
    tx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
`ifdef RX_ERR_COUNT_EN
    exp_err = 0;
    total++;
    if (err_count !== 8'd0) begin bad++; $display("FAIL midreset_err_count: got %0d expected 0", err_count); end
`endif
    // Payload 001 with parity bit set: two ones in total, so even parity holds.
    handshake(10'h201, 8, a, n, dr, lat);
    total++;
    if ({a, n, dr} !== 3'b100) begin bad++; $display("FAIL post_reset_ack: got %b expected 100", {a, n, dr}); end
    @(negedge clk);
    pop_expect(9'h001, "post_reset_data");
    total++;
    if (rx_valid !== 1'b0) begin bad++; $display("FAIL post_reset_empty: rx_valid=%b expected 0", rx_valid); end
  endtask

  initial begin
    test_reset();
    test_good_word();
    test_retry_drop();
    test_retry_recover();
    test_full_stall();
    test_push_pop_same_cycle();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
